mem_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of the 4-word × 3-bit latch memory and owns its D/SEL/E pins. It turns a valid/ready push stream and a valid/ready pop stream into glitch-free, properly sequenced latch write strobes and read selects, giving a 4-deep, 3-bit-wide FIFO. The memory is level-sensitive with a single shared SEL for read and write, so the controller time-multiplexes SEL and brackets every write strobe with setup and hold cycles.

---
 rtl/mem_fifo_ctrl.sv | 93 +++++++++
 tb/tb_mem_fifo_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_ctrl.sv
// 4-deep x 3-bit FIFO controller driving a level-sensitive latch memory (D/SEL/E).
// Latency: push accepted at edge k -> strobe k+1..k+2, readable from edge k+3; pops 1/cycle while IDLE.
// Backpressure: IN_READY only in IDLE and not full; OUT_VALID only in IDLE and not empty.
module mem_fifo_ctrl (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] IN_D,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [2:0] OUT_D,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [2:0] MEM_D,
    output logic [1:0] MEM_SEL,
    output logic       MEM_E,
    input  logic [2:0] MEM_Q,
    output logic [2:0] COUNT,
    output logic       FULL,
    output logic       EMPTY
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WSETUP  = 2'd1;
    localparam logic [1:0] WSTROBE = 2'd2;
    localparam logic [1:0] WHOLD   = 2'd3;

    logic [1:0] state;
    logic [1:0] nextState;
    logic [1:0] wrPtr;
    logic [1:0] rdPtr;
    logic [2:0] count;
    logic [2:0] wdata;
    logic       memE;
    logic       isIdle;
    logic       pushAcc;
    logic       popAcc;

    assign isIdle    = (state == IDLE);
    assign FULL      = (count == 3'd4);
    assign EMPTY     = (count == 3'd0);
    assign COUNT     = count;
    assign IN_READY  = isIdle & ~FULL;
    assign OUT_VALID = isIdle & ~EMPTY;
    assign pushAcc   = IN_VALID & IN_READY;
    assign popAcc    = OUT_READY & OUT_VALID;

    // SEL is shared by read and write: it only swaps while E is low on both sides of the edge.
    assign MEM_SEL = isIdle ? rdPtr : wrPtr;
    assign MEM_D   = wdata;
    assign MEM_E   = memE;
    assign OUT_D   = MEM_Q;

    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = pushAcc ? WSETUP : IDLE;
            WSETUP:  nextState = WSTROBE;
            WSTROBE: nextState = WHOLD;
            WHOLD:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            memE  <= 1'b0;
            wrPtr <= 2'd0;
            rdPtr <= 2'd0;
            count <= 3'd0;
            wdata <= 3'd0;
        end else begin
            state <= nextState;
            // Strobe comes straight from a flop so the latch enable cannot glitch.
            memE  <= (nextState == WSTROBE);
            if (pushAcc) begin
                wdata <= IN_D;
            end
            if (state == WHOLD) begin
                wrPtr <= wrPtr + 2'd1;
            end
            if (popAcc) begin
                rdPtr <= rdPtr + 2'd1;
            end
            case ({pushAcc, popAcc})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: latch memory model, queue-based reference, directed and random traffic.
module tb_mem_fifo_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [2:0] IN_D = 3'd0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [2:0] OUT_D;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [2:0] MEM_D;
    logic [1:0] MEM_SEL;
    logic       MEM_E;
    logic [2:0] MEM_Q;
    logic [2:0] COUNT;
    logic       FULL;
    logic       EMPTY;

    int errors = 0;
    int checks = 0;

    mem_fifo_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_D(IN_D), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_D(OUT_D), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .MEM_D(MEM_D), .MEM_SEL(MEM_SEL), .MEM_E(MEM_E), .MEM_Q(MEM_Q),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    // Level-sensitive 4x3 latch memory with a shared select.
    logic [2:0] mem [4];
    always @(MEM_E, MEM_SEL, MEM_D) if (MEM_E) mem[MEM_SEL] = MEM_D;
    assign MEM_Q = mem[MEM_SEL];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: FIFO contents as a queue, plus cycles remaining until the write finishes.
    logic [2:0] q [$];
    int         busy = 0;
    int         pushes = 0;
    int         pops = 0;
    logic [2:0] lastD = 3'd0;

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            q.delete();
            busy = 0; pushes = 0; pops = 0; lastD = 3'd0;
        end else begin
            automatic bit eReady = (busy == 0) && (q.size() < 4);
            automatic bit eValid = (busy == 0) && (q.size() > 0);
            automatic bit doPush = IN_VALID && eReady;
            automatic bit doPop  = OUT_READY && eValid;
            if (doPop) begin
                void'(q.pop_front());
                pops++;
            end
            if (doPush) begin
                q.push_back(IN_D);
                lastD = IN_D;
                pushes++;
                busy = 3;
            end else if (busy > 0) begin
                busy--;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (RST_N) begin
            automatic bit eReady = (busy == 0) && (q.size() < 4);
            automatic bit eValid = (busy == 0) && (q.size() > 0);
            automatic int eSel   = (busy > 0) ? ((pushes - 1) & 3) : (pops & 3);
            check("in_ready",  int'(IN_READY),  int'(eReady));
            check("out_valid", int'(OUT_VALID), int'(eValid));
            check("count",     int'(COUNT),     q.size());
            check("full",      int'(FULL),      int'(q.size() == 4));
            check("empty",     int'(EMPTY),     int'(q.size() == 0));
            check("mem_e",     int'(MEM_E),     int'(busy == 2));
            check("mem_sel",   int'(MEM_SEL),   eSel);
            check("mem_d",     int'(MEM_D),     int'(lastD));
            if (eValid) check("out_d", int'(OUT_D), int'(q[0]));
        end
    end

    // Strobe hygiene over a sliding three-sample window centred on each strobe cycle.
    logic       e0, e1, e2;
    logic [1:0] s0, s1, s2;
    logic [2:0] d0, d1, d2;
    int         hist = 0;
    initial forever begin
        @(negedge CLK);
        if (!RST_N) begin
            hist = 0;
        end else begin
            e2 = e1; s2 = s1; d2 = d1;
            e1 = e0; s1 = s0; d1 = d0;
            e0 = MEM_E; s0 = MEM_SEL; d0 = MEM_D;
            if (hist < 3) hist++;
            if (hist >= 3 && e1) begin
                check("strobe_sel_stable", int'(s2 == s1 && s1 == s0), 1);
                check("strobe_d_stable",   int'(d2 == d1 && d1 == d0), 1);
                check("strobe_single",     int'(!e0 && !e2), 1);
            end
        end
    end

    logic [1:0] strobeSel [$];
    initial forever begin
        @(negedge CLK);
        if (MEM_E) strobeSel.push_back(MEM_SEL);
    end

    task automatic pushW(input logic [2:0] d);
        bit ok = 0;
        @(posedge CLK); #1;
        IN_D = d; IN_VALID = 1'b1;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge CLK);
            if (IN_READY) ok = 1;
        end
        if (!ok) check("push_wait", int'(IN_READY), 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic popW(output logic [2:0] d);
        bit ok = 0;
        d = 3'd0;
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge CLK);
            if (OUT_VALID) ok = 1;
        end
        if (!ok) check("pop_wait", int'(OUT_VALID), 1);
        d = OUT_D;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
    endtask

    task automatic waitValid();
        bit ok = 0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge CLK);
            if (OUT_VALID) ok = 1;
        end
        if (!ok) check("valid_wait", int'(OUT_VALID), 1);
    endtask

    initial begin
        logic [2:0] d;
        logic [2:0] fillData [4];
        fillData[0] = 3'b101; fillData[1] = 3'b010;
        fillData[2] = 3'b111; fillData[3] = 3'b001;

        #2 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_count", int'(COUNT), 0);
        check("rst_empty", int'(EMPTY), 1);
        check("rst_full", int'(FULL), 0);
        check("rst_in_ready", int'(IN_READY), 1);
        check("rst_out_valid", int'(OUT_VALID), 0);
        check("rst_mem_e", int'(MEM_E), 0);
        check("rst_mem_sel", int'(MEM_SEL), 0);
        check("rst_mem_d", int'(MEM_D), 0);

        // Fill and drain
        strobeSel.delete();
        for (int i = 0; i < 4; i++) pushW(fillData[i]);
        repeat (4) @(negedge CLK);
        check("fill_strobes", strobeSel.size(), 4);
        for (int i = 0; i < 4 && i < strobeSel.size(); i++)
            check("fill_strobe_sel", int'(strobeSel[i]), i);
        check("fill_full", int'(FULL), 1);
        check("fill_in_ready", int'(IN_READY), 0);
        for (int i = 0; i < 4; i++) begin
            popW(d);
            check("drain_data", int'(d), int'(fillData[i]));
        end
        @(negedge CLK);
        check("drain_empty", int'(EMPTY), 1);

        // Wrap-around
        for (int i = 0; i < 10; i++) begin
            pushW(3'(i % 8));
            popW(d);
            check("wrap_data", int'(d), i % 8);
            check("wrap_count_le1", int'(COUNT <= 3'd1), 1);
        end

        // Simultaneous push and pop at COUNT = 2
        pushW(3'd3);
        pushW(3'd4);
        waitValid();
        @(posedge CLK); #1;
        IN_D = 3'd5; IN_VALID = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        @(negedge CLK);
        check("simul_count", int'(COUNT), 2);
        check("simul_busy_valid", int'(OUT_VALID), 0);
        waitValid();
        check("simul_head", int'(OUT_D), 4);
        popW(d); check("simul_pop1", int'(d), 4);
        popW(d); check("simul_pop2", int'(d), 5);

        // Push while FULL and popping
        for (int i = 1; i <= 4; i++) pushW(3'(i));
        waitValid();
        @(posedge CLK); #1;
        IN_D = 3'd6; IN_VALID = 1'b1; OUT_READY = 1'b1;
        @(negedge CLK);
        check("full_pop_in_ready", int'(IN_READY), 0);
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        @(negedge CLK);
        check("full_pop_count", int'(COUNT), 3);
        check("full_pop_ready_again", int'(IN_READY), 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("full_push_after", int'(COUNT), 4);
        for (int i = 2; i <= 4; i++) begin
            popW(d); check("full_drain", int'(d), i);
        end
        popW(d); check("full_drain_last", int'(d), 6);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK); #1;
            IN_VALID  = 1'($urandom % 2);
            IN_D      = 3'($urandom);
            OUT_READY = 1'(($urandom % 3) != 0);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        repeat (4) @(posedge CLK);

        // Reset in the middle of a strobe
        pushW(3'd6);
        begin
            bit ok = 0;
            for (int n = 0; n < 10 && !ok; n++) begin
                @(negedge CLK);
                if (MEM_E) ok = 1;
            end
            check("midrst_strobe_seen", int'(MEM_E), 1);
        end
        #1 RST_N = 1'b0;
        #1 check("midrst_e_async", int'(MEM_E), 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("midrst_count", int'(COUNT), 0);
        check("midrst_empty", int'(EMPTY), 1);
        check("midrst_in_ready", int'(IN_READY), 1);
        check("midrst_mem_sel", int'(MEM_SEL), 0);
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
